// File: rtl/ws2812_pkg.sv
// ws2812_pkg
//   Shared definitions for the WS2812 receive path: timing defaults at a
//   100 MHz clock, the decoder state encoding and the error codes reported
//   on err_code.
package ws2812_pkg;

    localparam int unsigned BIT_THRESH_DEF     = 60;
    localparam int unsigned MIN_HIGH_DEF       = 10;
    localparam int unsigned MAX_HIGH_DEF       = 150;
    localparam int unsigned RESET_LOW_DEF      = 5000;
    localparam int unsigned PX_COUNT_WIDTH_DEF = 6;
    localparam int unsigned CNT_WIDTH_DEF      = 13;

    typedef enum logic [1:0] {
        ST_SYNC = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2
    } state_t;

    localparam logic [1:0] ERR_GLITCH  = 2'd1;
    localparam logic [1:0] ERR_STUCK   = 2'd2;
    localparam logic [1:0] ERR_PARTIAL = 2'd3;

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff
//   Two-flop synchronizer for a single asynchronous level input.
// Ports:
//   clk      in   system clock
//   reset_n  in   asynchronous reset, active low (both flops clear to 0)
//   d        in   asynchronous input
//   q        out  input synchronized to clk, two cycles of latency
module sync_2ff (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/ws2812_stream_decoder.sv
// ws2812_stream_decoder
//   Decodes a WS2812 serial line into 24-bit pixels (MSB first), numbers the
//   pixels within a frame and reports the end-of-frame latch gap.
// Ports:
//   clk          in   system clock
//   reset_n      in   asynchronous reset, active low
//   din          in   raw WS2812 line, asynchronous to clk
//   pixel        out  last complete pixel, first-received bit at [23]
//   pixel_valid  out  1-cycle strobe, pixel and px_num valid
//   px_num       out  0-based pixel index within the frame (saturating)
//   frame_done   out  1-cycle strobe at a latch gap that followed >=1 bit
//   frame_px     out  complete pixels in the frame, valid with frame_done
//   err          out  1-cycle error strobe
//   err_code     out  1 glitch, 2 stuck high, 3 partial pixel
module ws2812_stream_decoder
    import ws2812_pkg::*;
#(
    parameter int unsigned BIT_THRESH     = BIT_THRESH_DEF,
    parameter int unsigned MIN_HIGH       = MIN_HIGH_DEF,
    parameter int unsigned MAX_HIGH       = MAX_HIGH_DEF,
    parameter int unsigned RESET_LOW      = RESET_LOW_DEF,
    parameter int unsigned PX_COUNT_WIDTH = PX_COUNT_WIDTH_DEF,
    parameter int unsigned CNT_WIDTH      = CNT_WIDTH_DEF
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      din,
    output logic [23:0]               pixel,
    output logic                      pixel_valid,
    output logic [PX_COUNT_WIDTH-1:0] px_num,
    output logic                      frame_done,
    output logic [PX_COUNT_WIDTH:0]   frame_px,
    output logic                      err,
    output logic [1:0]                err_code
);

    localparam logic [CNT_WIDTH-1:0] T_BIT = CNT_WIDTH'(BIT_THRESH);
    localparam logic [CNT_WIDTH-1:0] T_MIN = CNT_WIDTH'(MIN_HIGH);
    localparam logic [CNT_WIDTH-1:0] T_MAX = CNT_WIDTH'(MAX_HIGH);
    localparam logic [CNT_WIDTH-1:0] T_GAP = CNT_WIDTH'(RESET_LOW - 1);

    logic                      din_s;
    logic                      din_d;
    logic                      rise;
    logic                      fall;
    logic                      lvl_edge;
    logic                      new_bit;
    state_t                    state;
    logic [CNT_WIDTH-1:0]      cnt;
    logic [22:0]               shreg;
    logic [4:0]                bit_cnt;
    logic [PX_COUNT_WIDTH-1:0] px_idx;
    logic [PX_COUNT_WIDTH:0]   frame_cnt;
    logic                      got_bit;

    sync_2ff u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (din),
        .q       (din_s)
    );

    always_comb begin
        rise     = din_s & ~din_d;
        fall     = ~din_s & din_d;
        lvl_edge = din_s ^ din_d;
        // On the falling-edge cycle cnt still holds the length of the high pulse.
        new_bit  = (cnt >= T_BIT);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_SYNC;
            din_d       <= 1'b0;
            cnt         <= '0;
            shreg       <= '0;
            bit_cnt     <= '0;
            px_idx      <= '0;
            frame_cnt   <= '0;
            got_bit     <= 1'b0;
            pixel       <= '0;
            pixel_valid <= 1'b0;
            px_num      <= '0;
            frame_done  <= 1'b0;
            frame_px    <= '0;
            err         <= 1'b0;
            err_code    <= '0;
        end else begin
            pixel_valid <= 1'b0;
            frame_done  <= 1'b0;
            err         <= 1'b0;
            din_d       <= din_s;

            if (lvl_edge)
                cnt <= '0;
            else if (cnt != '1)
                cnt <= cnt + 1'b1;

            case (state)
                ST_SYNC: begin
                    // >= rather than == so a saturated timer still releases SYNC.
                    if (!din_s && !lvl_edge && cnt >= T_GAP)
                        state <= ST_LOW;
                end

                ST_LOW: begin
                    if (rise) begin
                        state <= ST_HIGH;
                    end else if (!din_s && cnt == T_GAP) begin
                        if (bit_cnt != '0) begin
                            err      <= 1'b1;
                            err_code <= ERR_PARTIAL;
                        end
                        if (got_bit) begin
                            frame_done <= 1'b1;
                            frame_px   <= frame_cnt;
                        end
                        bit_cnt   <= '0;
                        px_idx    <= '0;
                        frame_cnt <= '0;
                        got_bit   <= 1'b0;
                    end
                end

                ST_HIGH: begin
                    if (fall && cnt < T_MIN) begin
                        err       <= 1'b1;
                        err_code  <= ERR_GLITCH;
                        bit_cnt   <= '0;
                        px_idx    <= '0;
                        frame_cnt <= '0;
                        got_bit   <= 1'b0;
                        state     <= ST_SYNC;
                    end else if (fall) begin
                        got_bit <= 1'b1;
                        shreg   <= {shreg[21:0], new_bit};
                        state   <= ST_LOW;
                        if (bit_cnt == 5'd23) begin
                            pixel       <= {shreg, new_bit};
                            pixel_valid <= 1'b1;
                            px_num      <= px_idx;
                            bit_cnt     <= '0;
                            if (px_idx != '1)
                                px_idx <= px_idx + 1'b1;
                            if (frame_cnt != '1)
                                frame_cnt <= frame_cnt + 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end else if (cnt == T_MAX) begin
                        err       <= 1'b1;
                        err_code  <= ERR_STUCK;
                        bit_cnt   <= '0;
                        px_idx    <= '0;
                        frame_cnt <= '0;
                        got_bit   <= 1'b0;
                        state     <= ST_SYNC;
                    end
                end

                default: state <= ST_SYNC;
            endcase
        end
    end

endmodule

// File: tb/tb_ws2812_stream_decoder.sv
`timescale 1ns/1ps
// tb_ws2812_stream_decoder
//   Self-checking bench: scenario tasks push expected pixels, frame ends and
//   error codes into queues; a negedge monitor pops them as the decoder
//   strobes its outputs.
module tb_ws2812_stream_decoder;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        din;
    logic [23:0] pixel;
    logic        pixel_valid;
    logic [5:0]  px_num;
    logic        frame_done;
    logic [6:0]  frame_px;
    logic        err;
    logic [1:0]  err_code;

    int          checks   = 0;
    int          failures = 0;
    int unsigned cyc      = 0;

    logic [29:0] exp_px_q[$];
    logic [6:0]  exp_fd_q[$];
    logic [1:0]  exp_err_q[$];

    int unsigned n_pv         = 0;
    int unsigned last_pv_cyc  = 0;
    int unsigned last_fd_cyc  = 0;
    int unsigned last_err_cyc = 0;

    ws2812_stream_decoder #(
        .BIT_THRESH     (60),
        .MIN_HIGH       (10),
        .MAX_HIGH       (150),
        .RESET_LOW      (5000),
        .PX_COUNT_WIDTH (6),
        .CNT_WIDTH      (13)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .din         (din),
        .pixel       (pixel),
        .pixel_valid (pixel_valid),
        .px_num      (px_num),
        .frame_done  (frame_done),
        .frame_px    (frame_px),
        .err         (err),
        .err_code    (err_code)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Scoreboard monitor
    always @(negedge clk) begin
        logic [29:0] e_px;
        logic [6:0]  e_fd;
        logic [1:0]  e_err;
        if (reset_n) begin
            if (pixel_valid) begin
                checks++;
                n_pv++;
                last_pv_cyc = cyc;
                if (exp_px_q.size() == 0) begin
                    failures++;
                    $display("FAIL pixel_unexpected got pixel=%h px_num=%0d, expected no strobe", pixel, px_num);
                end else begin
                    e_px = exp_px_q.pop_front();
                    if ({pixel, px_num} !== e_px) begin
                        failures++;
                        $display("FAIL pixel_value got pixel=%h px_num=%0d, expected pixel=%h px_num=%0d",
                                 pixel, px_num, e_px[29:6], e_px[5:0]);
                    end
                end
            end
            if (frame_done) begin
                checks++;
                last_fd_cyc = cyc;
                if (exp_fd_q.size() == 0) begin
                    failures++;
                    $display("FAIL frame_unexpected got frame_px=%0d, expected no strobe", frame_px);
                end else begin
                    e_fd = exp_fd_q.pop_front();
                    if (frame_px !== e_fd) begin
                        failures++;
                        $display("FAIL frame_px got %0d, expected %0d", frame_px, e_fd);
                    end
                end
            end
            if (err) begin
                checks++;
                last_err_cyc = cyc;
                if (exp_err_q.size() == 0) begin
                    failures++;
                    $display("FAIL err_unexpected got code=%0d, expected no strobe", err_code);
                end else begin
                    e_err = exp_err_q.pop_front();
                    if (err_code !== e_err) begin
                        failures++;
                        $display("FAIL err_code got %0d, expected %0d", err_code, e_err);
                    end
                end
            end
            if (pixel_valid || frame_done || err) begin
                checks++;
                if ((pixel_valid && (frame_done || err)) || (err && frame_done && err_code != 2'd3)) begin
                    failures++;
                    $display("FAIL strobe_overlap got pv=%b fd=%b err=%b code=%0d, expected exclusive strobes",
                             pixel_valid, frame_done, err, err_code);
                end
            end
        end
    end

    // Stimulus helpers. fast=0 uses 80/45 and 40/85; fast=1 uses 75/8 and 12/8.
    task automatic send_bit(input logic b, input bit fast);
        int unsigned hi;
        int unsigned lo;
        if (fast) begin
            hi = b ? 75 : 12;
            lo = 8;
        end else begin
            hi = b ? 80 : 40;
            lo = b ? 45 : 85;
        end
        din = 1'b1;
        repeat (hi) @(negedge clk);
        din = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    task automatic send_bits(input logic [23:0] v, input int unsigned n, input bit fast);
        for (int unsigned i = 0; i < n; i++)
            send_bit(v[23 - i], fast);
    endtask

    task automatic gap();
        din = 1'b0;
        repeat (5010) @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        din     = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        din     = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({pixel, pixel_valid, px_num, frame_done, frame_px, err, err_code} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got pixel=%h pv=%b px_num=%0d fd=%b frame_px=%0d err=%b code=%0d, expected all 0",
                     pixel, pixel_valid, px_num, frame_done, frame_px, err, err_code);
        end
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        checks++;
        if ({pixel, pixel_valid, frame_done, err} !== '0) begin
            failures++;
            $display("FAIL reset_release got pixel=%h pv=%b fd=%b err=%b, expected all 0",
                     pixel, pixel_valid, frame_done, err);
        end
    endtask

    task automatic test_single_pixel();
        int unsigned c0;
        int unsigned pv0;
        repeat (60 + 5040) @(negedge clk);
        pv0 = n_pv;
        exp_px_q.push_back({24'hA5C3F0, 6'd0});
        exp_fd_q.push_back(7'd1);
        send_bits(24'hA5C3F0, 23, 1'b0);
        din = 1'b1;
        repeat (40) @(negedge clk);
        din = 1'b0;
        c0  = cyc;
        gap();
        checks++;
        if (last_pv_cyc - c0 != 3) begin
            failures++;
            $display("FAIL pv_latency got %0d cycles, expected 3", last_pv_cyc - c0);
        end
        checks++;
        if (n_pv - pv0 != 1) begin
            failures++;
            $display("FAIL pv_count got %0d, expected 1", n_pv - pv0);
        end
        checks++;
        if (exp_px_q.size() + exp_fd_q.size() + exp_err_q.size() != 0) begin
            failures++;
            $display("FAIL single_pending got px=%0d fd=%0d err=%0d outstanding, expected 0",
                     exp_px_q.size(), exp_fd_q.size(), exp_err_q.size());
        end
    endtask

    task automatic test_multi_pixel();
        int unsigned pv0;
        logic [23:0] v;
        pv0 = n_pv;
        for (int unsigned i = 0; i < 52; i++) begin
            v = 24'h100000 + 24'(i);
            exp_px_q.push_back({v, 6'(i)});
            send_bits(v, 24, 1'b1);
        end
        exp_fd_q.push_back(7'd52);
        gap();
        checks++;
        if (n_pv - pv0 != 52) begin
            failures++;
            $display("FAIL multi_count got %0d, expected 52", n_pv - pv0);
        end
        checks++;
        if (exp_px_q.size() + exp_fd_q.size() + exp_err_q.size() != 0) begin
            failures++;
            $display("FAIL multi_pending got px=%0d fd=%0d err=%0d outstanding, expected 0",
                     exp_px_q.size(), exp_fd_q.size(), exp_err_q.size());
        end
    endtask

    task automatic test_mid_frame_start();
        int unsigned pv0;
        do_reset();
        pv0 = n_pv;
        send_bits(24'h5A5000, 12, 1'b1);
        send_bits(24'h123456, 24, 1'b1);
        gap();
        checks++;
        if (n_pv != pv0) begin
            failures++;
            $display("FAIL mid_frame_ignored got %0d strobes, expected 0", n_pv - pv0);
        end
        exp_px_q.push_back({24'h3C0FF0, 6'd0});
        exp_fd_q.push_back(7'd1);
        send_bits(24'h3C0FF0, 24, 1'b1);
        gap();
        checks++;
        if (exp_px_q.size() + exp_fd_q.size() + exp_err_q.size() != 0) begin
            failures++;
            $display("FAIL mid_frame_pending got px=%0d fd=%0d err=%0d outstanding, expected 0",
                     exp_px_q.size(), exp_fd_q.size(), exp_err_q.size());
        end
    endtask

    task automatic test_partial_pixel();
        int unsigned pv0;
        pv0 = n_pv;
        exp_err_q.push_back(2'd3);
        exp_fd_q.push_back(7'd0);
        send_bits(24'hABC000, 12, 1'b1);
        gap();
        checks++;
        if (last_fd_cyc != last_err_cyc) begin
            failures++;
            $display("FAIL partial_same_cycle got fd@%0d err@%0d, expected equal", last_fd_cyc, last_err_cyc);
        end
        checks++;
        if (n_pv != pv0) begin
            failures++;
            $display("FAIL partial_no_pixel got %0d strobes, expected 0", n_pv - pv0);
        end
        checks++;
        if (exp_px_q.size() + exp_fd_q.size() + exp_err_q.size() != 0) begin
            failures++;
            $display("FAIL partial_pending got px=%0d fd=%0d err=%0d outstanding, expected 0",
                     exp_px_q.size(), exp_fd_q.size(), exp_err_q.size());
        end
    endtask

    task automatic test_glitch();
        exp_err_q.push_back(2'd1);
        send_bits(24'hC30000, 8, 1'b1);
        din = 1'b1;
        repeat (5) @(negedge clk);
        din = 1'b0;
        repeat (20) @(negedge clk);
        checks++;
        if (exp_err_q.size() != 0) begin
            failures++;
            $display("FAIL glitch_err got %0d outstanding, expected 0", exp_err_q.size());
        end
        gap();
        exp_px_q.push_back({24'h96E1D2, 6'd0});
        exp_fd_q.push_back(7'd1);
        send_bits(24'h96E1D2, 24, 1'b1);
        gap();
        checks++;
        if (exp_px_q.size() + exp_fd_q.size() + exp_err_q.size() != 0) begin
            failures++;
            $display("FAIL glitch_pending got px=%0d fd=%0d err=%0d outstanding, expected 0",
                     exp_px_q.size(), exp_fd_q.size(), exp_err_q.size());
        end
    endtask

    task automatic test_stuck_and_reset();
        int unsigned c0;
        int unsigned pv0;
        logic [23:0] v;
        exp_err_q.push_back(2'd2);
        c0  = cyc;
        din = 1'b1;
        repeat (200) @(negedge clk);
        din = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (exp_err_q.size() != 0 || last_err_cyc - c0 != 154) begin
            failures++;
            $display("FAIL stuck_err got outstanding=%0d at %0d cycles, expected 0 at 154",
                     exp_err_q.size(), last_err_cyc - c0);
        end
        pv0 = n_pv;
        v   = 24'hAAAAAA;
        send_bits(v, 10, 1'b1);
        din = 1'b1;
        repeat (30) @(negedge clk);
        reset_n = 1'b0;
        #1;
        checks++;
        if ({pixel, pixel_valid, px_num, frame_done, frame_px, err, err_code} !== '0) begin
            failures++;
            $display("FAIL midpixel_reset got pixel=%h px_num=%0d frame_px=%0d code=%0d, expected all 0",
                     pixel, px_num, frame_px, err_code);
        end
        repeat (3) @(negedge clk);
        din     = 1'b0;
        reset_n = 1'b1;
        v       = v << 10;
        send_bits(v, 14, 1'b1);
        gap();
        checks++;
        if (n_pv != pv0) begin
            failures++;
            $display("FAIL post_reset_ignored got %0d strobes, expected 0", n_pv - pv0);
        end
        exp_px_q.push_back({24'h0F1E2D, 6'd0});
        exp_fd_q.push_back(7'd1);
        send_bits(24'h0F1E2D, 24, 1'b1);
        gap();
        checks++;
        if (exp_px_q.size() + exp_fd_q.size() + exp_err_q.size() != 0) begin
            failures++;
            $display("FAIL post_reset_pending got px=%0d fd=%0d err=%0d outstanding, expected 0",
                     exp_px_q.size(), exp_fd_q.size(), exp_err_q.size());
        end
    endtask

    initial begin
        reset_n = 1'b0;
        din     = 1'b0;
        test_reset();
        test_single_pixel();
        test_multi_pixel();
        test_mid_frame_start();
        test_partial_pixel();
        test_glitch();
        test_stuck_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
